snake_engine: RTL and testbench

//   Multi-segment snake movement engine for the 96x64 OLED game: a grid of 3x3-pixel cells.

---
 rtl/snake_engine.sv | 195 +++++++++++++++++++
 tb/tb_snake_engine.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/snake_engine.sv
// Snake movement engine for a cell-grid OLED game: direction, body shift register,
// growth on food, wall/self collision, optional edge wrap.
//   state | meaning
//   IDLE  | after reset, waiting for start
//   RUN   | playing; moves one cell per step_en
//   DEAD  | collision happened, body frozen until start
module snake_engine #(
  parameter int GRID_W   = 32,
  parameter int GRID_H   = 21,
  parameter int MAX_LEN  = 16,
  parameter int INIT_LEN = 3,
  parameter int WRAP     = 0,
  parameter int CW       = 6,
  parameter int LW       = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          step_en,
  input  logic          start,
  input  logic          btnU,
  input  logic          btnD,
  input  logic          btnL,
  input  logic          btnR,
  input  logic [CW-1:0] food_x,
  input  logic [CW-1:0] food_y,
  input  logic          food_valid,
  input  logic [LW-1:0] seg_idx,
  output logic [CW-1:0] seg_x,
  output logic [CW-1:0] seg_y,
  output logic          seg_valid,
  output logic [CW-1:0] head_x,
  output logic [CW-1:0] head_y,
  output logic [LW-1:0] len,
  output logic          alive,
  output logic          ate,
  output logic          crash
);

  typedef enum logic [1:0] {IDLE, RUN, DEAD} state_t;
  typedef enum logic [1:0] {DIR_R, DIR_L, DIR_U, DIR_D} dir_t;

  state_t        state_q, state_d;
  dir_t          dir_q, dir_d, pend_q, pend_d, btn_dir;
  logic [LW-1:0] len_q, len_d;
  logic          ate_q, ate_d, crash_q, crash_d;
  logic [CW-1:0] seg_x_q [MAX_LEN];
  logic [CW-1:0] seg_y_q [MAX_LEN];
  logic [CW-1:0] seg_x_d [MAX_LEN];
  logic [CW-1:0] seg_y_d [MAX_LEN];
  logic [CW-1:0] nx, ny;
  logic          btn_vld, wall, eat, hit;

  function automatic logic [CW-1:0] init_x(input int k);
    return (k < INIT_LEN) ? CW'(GRID_W/2 - k) : '0;
  endfunction

  function automatic logic [CW-1:0] init_y(input int k);
    return (k < INIT_LEN) ? CW'(GRID_H/2) : '0;
  endfunction

  function automatic dir_t opposite(input dir_t d);
    case (d)
      DIR_R:   return DIR_L;
      DIR_L:   return DIR_R;
      DIR_U:   return DIR_D;
      default: return DIR_U;
    endcase
  endfunction

  always_comb begin
    btn_vld = 1'b1;
    btn_dir = DIR_R;
    if (btnU)      btn_dir = DIR_U;
    else if (btnD) btn_dir = DIR_D;
    else if (btnL) btn_dir = DIR_L;
    else if (btnR) btn_dir = DIR_R;
    else           btn_vld = 1'b0;
  end

  // Next head cell; the move always uses the pending direction being committed.
  always_comb begin
    nx   = seg_x_q[0];
    ny   = seg_y_q[0];
    wall = 1'b0;
    case (pend_q)
      DIR_R: if (seg_x_q[0] == CW'(GRID_W-1)) begin nx = '0; wall = (WRAP == 0); end
             else nx = seg_x_q[0] + 1'b1;
      DIR_L: if (seg_x_q[0] == '0) begin nx = CW'(GRID_W-1); wall = (WRAP == 0); end
             else nx = seg_x_q[0] - 1'b1;
      DIR_U: if (seg_y_q[0] == '0) begin ny = CW'(GRID_H-1); wall = (WRAP == 0); end
             else ny = seg_y_q[0] - 1'b1;
      default: if (seg_y_q[0] == CW'(GRID_H-1)) begin ny = '0; wall = (WRAP == 0); end
               else ny = seg_y_q[0] + 1'b1;
    endcase
    eat = food_valid && (nx == food_x) && (ny == food_y);
    // The tail only vacates its cell when the snake does not grow this step.
    hit = 1'b0;
    for (int k = 0; k < MAX_LEN; k++) begin
      if (seg_x_q[k] == nx && seg_y_q[k] == ny &&
          (LW'(k) < len_q - 1'b1 ||
           (eat && len_q < LW'(MAX_LEN) && LW'(k) == len_q - 1'b1)))
        hit = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    pend_d  = pend_q;
    len_d   = len_q;
    ate_d   = 1'b0;
    crash_d = 1'b0;
    seg_x_d = seg_x_q;
    seg_y_d = seg_y_q;
    case (state_q)
      IDLE: if (start) state_d = RUN;
      RUN: begin
        if (btn_vld && btn_dir != opposite(dir_q)) pend_d = btn_dir;
        if (step_en) begin
          if (wall || hit) begin
            state_d = DEAD;
            crash_d = 1'b1;
          end else begin
            dir_d = pend_q;
            for (int k = MAX_LEN-1; k >= 1; k--) begin
              seg_x_d[k] = seg_x_q[k-1];
              seg_y_d[k] = seg_y_q[k-1];
            end
            seg_x_d[0] = nx;
            seg_y_d[0] = ny;
            if (eat) begin
              ate_d = 1'b1;
              if (len_q < LW'(MAX_LEN)) len_d = len_q + 1'b1;
            end
          end
        end
      end
      DEAD: if (start) begin
        state_d = RUN;
        dir_d   = DIR_R;
        pend_d  = DIR_R;
        len_d   = LW'(INIT_LEN);
        for (int k = 0; k < MAX_LEN; k++) begin
          seg_x_d[k] = init_x(k);
          seg_y_d[k] = init_y(k);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      dir_q   <= DIR_R;
      pend_q  <= DIR_R;
      len_q   <= LW'(INIT_LEN);
      ate_q   <= 1'b0;
      crash_q <= 1'b0;
      for (int k = 0; k < MAX_LEN; k++) begin
        seg_x_q[k] <= init_x(k);
        seg_y_q[k] <= init_y(k);
      end
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      pend_q  <= pend_d;
      len_q   <= len_d;
      ate_q   <= ate_d;
      crash_q <= crash_d;
      seg_x_q <= seg_x_d;
      seg_y_q <= seg_y_d;
    end
  end

  always_comb begin
    seg_x = '0;
    seg_y = '0;
    for (int k = 0; k < MAX_LEN; k++) begin
      if (seg_idx == LW'(k)) begin
        seg_x = seg_x_q[k];
        seg_y = seg_y_q[k];
      end
    end
  end

  assign seg_valid = (seg_idx < len_q);
  assign head_x    = seg_x_q[0];
  assign head_y    = seg_y_q[0];
  assign len       = len_q;
  assign alive     = (state_q == RUN);
  assign ate       = ate_q;
  assign crash     = crash_q;

endmodule

// File: tb/tb_snake_engine.sv
// Directed bench for snake_engine: a crash-at-wall instance plus a wrapping
// instance driven by the same stimulus.
module tb_snake_engine;
  localparam int CW = 6;
  localparam int LW = 5;

  logic clk = 1'b0;
  logic rst_n, step_en, start, btnU, btnD, btnL, btnR, food_valid;
  logic [CW-1:0] food_x, food_y;
  logic [LW-1:0] seg_idx;

  logic [CW-1:0] seg_x, seg_y, head_x, head_y;
  logic [LW-1:0] len;
  logic seg_valid, alive, ate, crash;

  logic [CW-1:0] w_seg_x, w_seg_y, w_head_x, w_head_y;
  logic [LW-1:0] w_len;
  logic w_seg_valid, w_alive, w_ate, w_crash;

  int tests = 0;
  int fails = 0;

  snake_engine #(.WRAP(0)) dut (
    .clk(clk), .rst_n(rst_n), .step_en(step_en), .start(start),
    .btnU(btnU), .btnD(btnD), .btnL(btnL), .btnR(btnR),
    .food_x(food_x), .food_y(food_y), .food_valid(food_valid), .seg_idx(seg_idx),
    .seg_x(seg_x), .seg_y(seg_y), .seg_valid(seg_valid),
    .head_x(head_x), .head_y(head_y), .len(len),
    .alive(alive), .ate(ate), .crash(crash)
  );

  snake_engine #(.WRAP(1)) dut_w (
    .clk(clk), .rst_n(rst_n), .step_en(step_en), .start(start),
    .btnU(btnU), .btnD(btnD), .btnL(btnL), .btnR(btnR),
    .food_x(food_x), .food_y(food_y), .food_valid(food_valid), .seg_idx(seg_idx),
    .seg_x(w_seg_x), .seg_y(w_seg_y), .seg_valid(w_seg_valid),
    .head_x(w_head_x), .head_y(w_head_y), .len(w_len),
    .alive(w_alive), .ate(w_ate), .crash(w_crash)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_head(input string tag, input int x, input int y);
    chk({tag, ".x"}, 32'(head_x), 32'(x));
    chk({tag, ".y"}, 32'(head_y), 32'(y));
  endtask

  task automatic chk_seg(input string tag, input int idx, input int x, input int y, input logic v);
    seg_idx = LW'(idx);
    #1;
    chk({tag, ".x"}, 32'(seg_x), 32'(x));
    chk({tag, ".y"}, 32'(seg_y), 32'(y));
    chk({tag, ".valid"}, 32'(seg_valid), 32'(v));
  endtask

  task automatic step();
    @(negedge clk); step_en = 1'b1;
    @(negedge clk); step_en = 1'b0;
  endtask

  task automatic nsteps(input int n);
    repeat (n) step();
  endtask

  task automatic press(input logic u, input logic d, input logic l, input logic r);
    @(negedge clk); {btnU, btnD, btnL, btnR} = {u, d, l, r};
    @(negedge clk); {btnU, btnD, btnL, btnR} = 4'b0000;
  endtask

  task automatic do_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic eat_at(input int x, input int y);
    food_x = CW'(x); food_y = CW'(y); food_valid = 1'b1;
    step();
    food_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; step_en = 1'b0; start = 1'b0;
    {btnU, btnD, btnL, btnR} = 4'b0000;
    food_x = '0; food_y = '0; food_valid = 1'b0; seg_idx = '0;
    #12;
    chk("rst.alive", 32'(alive), 0);
    chk("rst.len", 32'(len), 3);
    chk("rst.ate", 32'(ate), 0);
    chk("rst.crash", 32'(crash), 0);
    chk_head("rst.head", 16, 10);
    chk_seg("rst.seg2", 2, 14, 10, 1'b1);
    chk_seg("rst.seg3", 3, 0, 0, 1'b0);
    chk_seg("rst.seg20", 20, 0, 0, 1'b0);
    @(negedge clk); rst_n = 1'b1;

    step();
    chk_head("idle.step_ignored", 16, 10);
    do_start();
    chk("start.alive", 32'(alive), 1);
    nsteps(3);
    chk_head("t1.head", 19, 10);
    chk("t1.len", 32'(len), 3);
    chk("t1.ate", 32'(ate), 0);
    chk("t1.crash", 32'(crash), 0);
    chk_seg("t1.seg2", 2, 17, 10, 1'b1);

    press(0, 0, 1, 0);
    step();
    chk_head("t2.reverse_ignored", 20, 10);
    press(1, 0, 0, 1);
    step();
    chk_head("t2.up_wins", 20, 9);
    @(negedge clk); step_en = 1'b1; btnR = 1'b1;
    @(negedge clk); step_en = 1'b0; btnR = 1'b0;
    chk_head("t2.same_cycle_btn", 20, 8);
    step();
    chk_head("t2.next_step_right", 21, 8);

    eat_at(22, 8);
    chk("t3.ate", 32'(ate), 1);
    chk("t3.len", 32'(len), 4);
    chk_head("t3.head", 22, 8);
    chk_seg("t3.old_tail", 3, 20, 9, 1'b1);
    @(negedge clk);
    chk("t3.ate_pulse_end", 32'(ate), 0);

    press(0, 1, 0, 0);
    for (int i = 0; i < 12; i++) eat_at(22, 9 + i);
    chk("t3.len_max", 32'(len), 16);
    chk_head("t3.head_max", 22, 20);
    press(0, 0, 1, 0);
    eat_at(21, 20);
    chk("t3.sat_ate", 32'(ate), 1);
    chk("t3.sat_len", 32'(len), 16);
    chk_head("t3.sat_head", 21, 20);
    chk_seg("t3.sat_tail", 15, 20, 8, 1'b1);

    rst_n = 1'b0;
    #1;
    chk("t6.rst_alive", 32'(alive), 0);
    chk("t6.rst_ate", 32'(ate), 0);
    chk("t6.rst_len", 32'(len), 3);
    chk_head("t6.rst_head", 16, 10);
    chk_seg("t6.rst_seg1", 1, 15, 10, 1'b1);
    @(negedge clk); rst_n = 1'b1;

    do_start();
    press(1, 0, 0, 0);
    nsteps(5);
    chk_head("t4.up5", 16, 5);
    press(0, 0, 0, 1);
    nsteps(15);
    chk_head("t4.edge", 31, 5);
    chk("t4.w_edge_x", 32'(w_head_x), 31);
    step();
    chk("t4.crash", 32'(crash), 1);
    chk("t4.alive", 32'(alive), 0);
    chk("t4.len", 32'(len), 3);
    chk_head("t4.frozen", 31, 5);
    chk("t4.w_head_x", 32'(w_head_x), 0);
    chk("t4.w_head_y", 32'(w_head_y), 5);
    chk("t4.w_alive", 32'(w_alive), 1);
    chk("t4.w_crash", 32'(w_crash), 0);
    @(negedge clk);
    chk("t4.crash_pulse_end", 32'(crash), 0);

    step();
    chk_head("t6.dead_step_ignored", 31, 5);
    do_start();
    chk("t6.restart_alive", 32'(alive), 1);
    chk("t6.restart_len", 32'(len), 3);
    chk("t6.restart_crash", 32'(crash), 0);
    chk_head("t6.restart_head", 16, 10);
    chk_seg("t6.restart_seg1", 1, 15, 10, 1'b1);
    step();
    chk_head("t6.restart_step", 17, 10);

    eat_at(18, 10);
    eat_at(19, 10);
    chk("t5.len5", 32'(len), 5);
    press(1, 0, 0, 0);
    step();
    chk("t5.turn1_crash", 32'(crash), 0);
    chk_head("t5.turn1", 19, 9);
    press(0, 0, 1, 0);
    step();
    chk("t5.turn2_crash", 32'(crash), 0);
    chk_head("t5.turn2", 18, 9);
    press(0, 1, 0, 0);
    step();
    chk("t5.turn3_crash", 32'(crash), 1);
    chk("t5.turn3_alive", 32'(alive), 0);
    chk("t5.turn3_len", 32'(len), 5);
    chk_head("t5.turn3_frozen", 18, 9);

    do_start();
    eat_at(17, 10);
    chk("t5.len4", 32'(len), 4);
    press(1, 0, 0, 0); step();
    press(0, 0, 1, 0); step();
    press(0, 1, 0, 0); step();
    chk("t5.tail_crash", 32'(crash), 0);
    chk("t5.tail_alive", 32'(alive), 1);
    chk_head("t5.tail_head", 16, 10);
    press(0, 0, 0, 1);
    eat_at(17, 10);
    chk("t5.grow_tail_crash", 32'(crash), 1);
    chk("t5.grow_tail_ate", 32'(ate), 0);
    chk("t5.grow_tail_len", 32'(len), 4);
    chk_head("t5.grow_tail_head", 16, 10);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
